// File: rtl/load_align_unit.sv
// Sequential little-endian load unit: aligned bus reads, B/H/W(/D) lane extraction, sign/zero extension.
// Optional macro LOAD_UNALIGNED_EN enables misaligned loads (in-word shift or two-beat merge).
module load_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RID_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [RID_WIDTH-1:0]  req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [RID_WIDTH-1:0]  wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_exc,
  output logic [ADDR_WIDTH-1:0] wb_badvaddr
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFFW   = $clog2(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE, S_EXC
  } state_t;

  state_t state, state_next;

  logic [1:0]            size_q;
  logic                  signed_q;
  logic [OFFW-1:0]       off_q;
  logic                  split_q;
  logic [RID_WIDTH-1:0]  rd_q;
  logic [DATA_WIDTH-1:0] beat0_q;

  logic [OFFW-1:0]       req_off;
  logic [ADDR_WIDTH-1:0] beat0_addr;
  logic                  req_misaligned;
  logic                  size_bad;
  logic                  req_exc;
  logic                  req_split;

  assign req_off    = req_addr[OFFW-1:0];
  assign beat0_addr = {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign size_bad   = (DATA_WIDTH == 32) && (req_size == 2'd3);
  assign req_ready  = (state == S_IDLE);

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      2'd3:    req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

`ifdef LOAD_UNALIGNED_EN
  logic [4:0] span_end;
  assign span_end  = 5'(req_off) + (5'd1 << req_size);
  assign req_exc   = size_bad;
  assign req_split = span_end > 5'(NBYTES);
`else
  assign req_exc   = size_bad || req_misaligned;
  assign req_split = 1'b0;
`endif

  // Lane merge: second beat sits above the first, then shift down by the byte offset.
  logic [2*DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0]   low;
  logic [DATA_WIDTH-1:0]   mask;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    sign_bit;

  always_comb begin
    pair = (state == S_WAIT1) ? {mem_resp_data, beat0_q}
                              : {{DATA_WIDTH{1'b0}}, mem_resp_data};
    low  = DATA_WIDTH'(pair >> (8 * off_q));
    case (size_q)
      2'd0: begin
        mask     = ~({DATA_WIDTH{1'b1}} << 8);
        sign_bit = low[7];
      end
      2'd1: begin
        mask     = ~({DATA_WIDTH{1'b1}} << 16);
        sign_bit = low[15];
      end
      2'd2: begin
        mask     = ~({DATA_WIDTH{1'b1}} << 32);
        sign_bit = low[31];
      end
      default: begin
        mask     = {DATA_WIDTH{1'b1}};
        sign_bit = low[DATA_WIDTH-1];
      end
    endcase
    load_data = (low & mask) | ((signed_q && sign_bit) ? ~mask : {DATA_WIDTH{1'b0}});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = req_exc ? S_EXC : S_REQ0;
      S_REQ0:  if (mem_req_valid && mem_req_ready) state_next = S_WAIT0;
      S_WAIT0: if (mem_resp_valid) state_next = split_q ? S_REQ1 : S_DONE;
      S_REQ1:  if (mem_req_valid && mem_req_ready) state_next = S_WAIT1;
      S_WAIT1: if (mem_resp_valid) state_next = S_DONE;
      S_DONE,
      S_EXC:   if (wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      size_q        <= '0;
      signed_q      <= 1'b0;
      off_q         <= '0;
      split_q       <= 1'b0;
      rd_q          <= '0;
      beat0_q       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exc        <= 1'b0;
      wb_badvaddr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            size_q   <= req_size;
            signed_q <= req_signed;
            off_q    <= req_off;
            split_q  <= req_split;
            rd_q     <= req_rd;
            if (req_exc) begin
              wb_valid    <= 1'b1;
              wb_exc      <= 1'b1;
              wb_badvaddr <= req_addr;
              wb_data     <= '0;
              wb_rd       <= req_rd;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= beat0_addr;
            end
          end
        end
        S_REQ0, S_REQ1: begin
          if (mem_req_ready) mem_req_valid <= 1'b0;
        end
        S_WAIT0, S_WAIT1: begin
          if (mem_resp_valid) begin
            if (state == S_WAIT0 && split_q) begin
              beat0_q       <= mem_resp_data;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + ADDR_WIDTH'(NBYTES);
            end else begin
              wb_valid    <= 1'b1;
              wb_exc      <= 1'b0;
              wb_badvaddr <= '0;
              wb_data     <= load_data;
              wb_rd       <= rd_q;
            end
          end
        end
        S_DONE, S_EXC: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            wb_exc   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
